// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Brief    : Operand/opcode request and result bundle for seq_alu.
// Revision : 1.0  initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       n;
    logic [WIDTH-1:0] r;
    logic [3:0]       cc;
    logic             carry;
    logic             writeEnable;
    logic             out_valid;

    modport master (
        output in_valid, a, b, n,
        input  in_ready, r, cc, carry, writeEnable, out_valid
    );

    modport slave (
        input  in_valid, a, b, n,
        output in_ready, r, cc, carry, writeEnable, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Clocked ALU: single-cycle ops 0-7, iterative mul/div/rem 8-10.
// Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_MUL2  = 4'd2;
    localparam logic [3:0] c_OP_DIV2  = 4'd3;
    localparam logic [3:0] c_OP_PASSA = 4'd4;
    localparam logic [3:0] c_OP_PASSB = 4'd5;
    localparam logic [3:0] c_OP_MAX   = 4'd6;
    localparam logic [3:0] c_OP_MIN   = 4'd7;
    localparam logic [3:0] c_OP_MUL   = 4'd8;
    localparam logic [3:0] c_OP_DIV   = 4'd9;
    localparam logic [3:0] c_OP_REM   = 4'd10;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_r;
    logic [3:0]       r_cc;
    logic             r_carry;
    logic             r_we;
    logic             r_ov;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_a_ge_b;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_cc;
    logic             w_carry;
    logic             w_accept;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_div_res;

    assign w_accept = bus.in_valid && (r_state == c_S_IDLE);

    // Single-cycle datapath, evaluated straight from the request operands.
    always_comb begin
        w_add    = {1'b0, bus.a} + {1'b0, bus.b};
        w_sub    = {1'b0, bus.a} - {1'b0, bus.b};
        w_a_ge_b = (bus.a >= bus.b);
        w_res    = '0;
        w_cc     = '0;
        w_carry  = 1'b0;
        case (bus.n)
            c_OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_cc[0] = 1'b1;
            end
            c_OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_cc[0] = 1'b1;
            end
            c_OP_MUL2: begin
                w_res   = {bus.a[WIDTH-2:0], 1'b0};
                w_carry = bus.a[WIDTH-1];
                w_cc[0] = 1'b1;
            end
            c_OP_DIV2: begin
                w_res   = {1'b0, bus.a[WIDTH-1:1]};
                w_carry = bus.a[0];
                w_cc[0] = 1'b1;
            end
            c_OP_PASSA: w_res = bus.a;
            c_OP_PASSB: w_res = bus.b;
            c_OP_MAX: begin
                if (w_a_ge_b) begin
                    w_res   = bus.a;
                    w_cc[2] = 1'b1;
                end else begin
                    w_res   = bus.b;
                    w_cc[3] = 1'b1;
                end
            end
            c_OP_MIN: begin
                if (!w_a_ge_b) begin
                    w_res   = bus.a;
                    w_cc[3] = 1'b1;
                end else begin
                    w_res   = bus.b;
                    w_cc[2] = 1'b1;
                end
            end
            default: begin
                w_res = '0;
            end
        endcase
        w_cc[1] = w_cc[0] && (w_res == '0);
    end

    // Shift-add step: {hi,lo} starts as {0,b}; each step adds a when lo[0] is set
    // and shifts right, so after WIDTH steps {hi,lo} holds the full product.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_hi_nxt  = w_mul_sum[WIDTH:1];
        w_lo_nxt  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end

    // Restoring division step; the partial remainder is kept below b, so one
    // extra bit is enough to detect whether the trial subtraction fits.
    always_comb begin
        w_shift   = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_b};
        w_fits    = !w_trial[WIDTH];
        w_rem_nxt = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
        w_div_res = (r_op == c_OP_DIV) ? w_quo_nxt : w_rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_r     <= '0;
            r_cc    <= '0;
            r_carry <= 1'b0;
            r_we    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_ov <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_op  <= bus.n;
                        r_cnt <= '0;
                        if (bus.n == c_OP_MUL) begin
                            r_state <= c_S_MUL;
                            r_hi    <= '0;
                            r_lo    <= bus.b;
                        end else if ((bus.n == c_OP_DIV) || (bus.n == c_OP_REM)) begin
                            r_state <= c_S_DIV;
                            r_rem   <= '0;
                            r_quo   <= bus.a;
                        end else if (bus.n <= c_OP_MIN) begin
                            r_r     <= w_res;
                            r_cc    <= w_cc;
                            r_carry <= w_carry;
                            r_we    <= 1'b1;
                            r_ov    <= 1'b1;
                        end else begin
                            // Unknown opcode: signal completion but keep r.
                            r_cc    <= '0;
                            r_carry <= 1'b0;
                            r_ov    <= 1'b1;
                        end
                    end
                end
                c_S_MUL: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_S_IDLE;
                        r_r     <= w_lo_nxt;
                        r_carry <= |w_hi_nxt;
                        r_cc    <= {2'b00, (w_lo_nxt == '0), 1'b1};
                        r_we    <= 1'b1;
                        r_ov    <= 1'b1;
                    end
                end
                c_S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_S_IDLE;
                        r_we    <= 1'b1;
                        r_ov    <= 1'b1;
                        if (r_b == '0) begin
                            r_r     <= (r_op == c_OP_DIV) ? {WIDTH{1'b1}} : r_a;
                            r_cc    <= 4'b1001;
                            r_carry <= 1'b1;
                        end else begin
                            r_r     <= w_div_res;
                            r_cc    <= {2'b00, (w_div_res == '0), 1'b1};
                            r_carry <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == c_S_IDLE);
    assign bus.r           = r_r;
    assign bus.cc          = r_cc;
    assign bus.carry       = r_carry;
    assign bus.writeEnable = r_we;
    assign bus.out_valid   = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu at WIDTH=8 and WIDTH=16.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    seq_alu_if #(.WIDTH(8))  bus8 ();
    seq_alu_if #(.WIDTH(16)) bus16 ();

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    seq_alu #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        bus8.in_valid = 1'b1;
        bus8.a        = av;
        bus8.b        = bv;
        bus8.n        = op;
        tick();
    endtask

    task automatic chk_res8(input string tag, input logic [7:0] er, input logic [3:0] ecc,
                            input logic ec, input logic ewe);
        chk({tag, ".ov"},    32'(bus8.out_valid),   32'd1);
        chk({tag, ".r"},     32'(bus8.r),           32'(er));
        chk({tag, ".cc"},    32'(bus8.cc),          32'(ecc));
        chk({tag, ".carry"}, 32'(bus8.carry),       32'(ec));
        chk({tag, ".we"},    32'(bus8.writeEnable), 32'(ewe));
    endtask

    // Waits (bounded) for completion of a multi-cycle op on the 8-bit DUT,
    // optionally wiggling the request while busy.
    task automatic wait_done8(input string tag, input bit noisy);
        int k;
        int ready_seen;
        k          = 0;
        ready_seen = 0;
        if (!noisy) bus8.in_valid = 1'b0;
        while (!bus8.out_valid && k < 64) begin
            if (bus8.in_ready) ready_seen++;
            if (noisy) begin
                bus8.in_valid = ~bus8.in_valid;
                bus8.a        = 8'hFF;
                bus8.b        = 8'hFE;
                bus8.n        = 4'd0;
            end
            tick();
            k++;
        end
        bus8.in_valid = 1'b0;
        chk({tag, ".latency"},   32'(k),             32'd8);
        chk({tag, ".busy"},      32'(ready_seen),    32'd0);
        chk({tag, ".ready_back"},32'(bus8.in_ready), 32'd1);
    endtask

    initial begin
        int k;
        int ov_seen;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.n         = '0;
        bus16.in_valid = 1'b0;
        bus16.a        = '0;
        bus16.b        = '0;
        bus16.n        = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst.ready", 32'(bus8.in_ready),    32'd1);
        chk("rst.r",     32'(bus8.r),           32'd0);
        chk("rst.cc",    32'(bus8.cc),          32'd0);
        chk("rst.carry", 32'(bus8.carry),       32'd0);
        chk("rst.we",    32'(bus8.writeEnable), 32'd0);
        chk("rst.ov",    32'(bus8.out_valid),   32'd0);

        issue8(4'd0, 8'hF0, 8'h20);
        bus8.in_valid = 1'b0;
        chk_res8("add", 8'h10, 4'b0001, 1'b1, 1'b1);
        tick();
        chk("add.pulse", 32'(bus8.out_valid), 32'd0);
        chk("add.hold",  32'(bus8.r),         32'h10);

        issue8(4'd1, 8'd5, 8'd5);
        bus8.in_valid = 1'b0;
        chk_res8("sub0", 8'h00, 4'b0011, 1'b0, 1'b1);
        issue8(4'd1, 8'd3, 8'd5);
        chk_res8("sub_borrow", 8'hFE, 4'b0001, 1'b1, 1'b1);
        issue8(4'd2, 8'h80, 8'h00);
        chk_res8("mul2", 8'h00, 4'b0011, 1'b1, 1'b1);
        issue8(4'd3, 8'h81, 8'h00);
        chk_res8("div2", 8'h40, 4'b0001, 1'b1, 1'b1);

        // Back-to-back single-cycle accepts
        issue8(4'd6, 8'd3, 8'd9);
        chk_res8("max", 8'd9, 4'b1000, 1'b0, 1'b1);
        issue8(4'd7, 8'd3, 8'd9);
        chk_res8("min", 8'd3, 4'b1000, 1'b0, 1'b1);
        issue8(4'd5, 8'd3, 8'd7);
        chk_res8("passB", 8'd7, 4'b0000, 1'b0, 1'b1);
        issue8(4'd12, 8'd1, 8'd2);
        bus8.in_valid = 1'b0;
        chk_res8("unknown", 8'd7, 4'b0000, 1'b0, 1'b0);

        issue8(4'd8, 8'h13, 8'h11);
        wait_done8("mul_a", 1'b0);
        chk_res8("mul_a", 8'h43, 4'b0001, 1'b1, 1'b1);

        issue8(4'd8, 8'h0F, 8'h03);
        wait_done8("mul_busy", 1'b1);
        chk_res8("mul_busy", 8'h2D, 4'b0001, 1'b0, 1'b1);
        tick();
        chk("mul_busy.no_extra", 32'(bus8.out_valid), 32'd0);

        issue8(4'd9, 8'd200, 8'd7);
        wait_done8("div", 1'b0);
        chk_res8("div", 8'd28, 4'b0001, 1'b0, 1'b1);
        issue8(4'd10, 8'd200, 8'd7);
        wait_done8("rem", 1'b0);
        chk_res8("rem", 8'd4, 4'b0001, 1'b0, 1'b1);
        issue8(4'd9, 8'd9, 8'd0);
        wait_done8("div0", 1'b0);
        chk_res8("div0", 8'hFF, 4'b1001, 1'b1, 1'b1);
        issue8(4'd10, 8'd9, 8'd0);
        wait_done8("rem0", 1'b0);
        chk_res8("rem0", 8'd9, 4'b1001, 1'b1, 1'b1);

        // Reset in the middle of a divide
        issue8(4'd9, 8'd200, 8'd7);
        bus8.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort.ready", 32'(bus8.in_ready),    32'd1);
        chk("abort.r",     32'(bus8.r),           32'd0);
        chk("abort.cc",    32'(bus8.cc),          32'd0);
        chk("abort.carry", 32'(bus8.carry),       32'd0);
        chk("abort.we",    32'(bus8.writeEnable), 32'd0);
        chk("abort.ov",    32'(bus8.out_valid),   32'd0);
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.out_valid) ov_seen++;
        end
        chk("abort.no_ov", 32'(ov_seen), 32'd0);
        issue8(4'd0, 8'd1, 8'd1);
        bus8.in_valid = 1'b0;
        chk_res8("post_abort_add", 8'd2, 4'b0001, 1'b0, 1'b1);

        // WIDTH=16 instance
        bus16.in_valid = 1'b1;
        bus16.a        = 16'h0100;
        bus16.b        = 16'h0100;
        bus16.n        = 4'd8;
        tick();
        bus16.in_valid = 1'b0;
        k = 0;
        while (!bus16.out_valid && k < 64) begin
            tick();
            k++;
        end
        chk("mul16.latency", 32'(k),                  32'd16);
        chk("mul16.r",       32'(bus16.r),            32'd0);
        chk("mul16.carry",   32'(bus16.carry),        32'd1);
        chk("mul16.cc",      32'(bus16.cc),           32'b0011);
        chk("mul16.we",      32'(bus16.writeEnable),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
